nn_argmax_classifier: RTL

- Downstream stage of the MNIST network top: consumes the NumOutputs output-layer activations and their per-neuron req/ack handshakes.
- Captures one full frame of activations, then scans them sequentially and reports the index and value of the largest activation.
- Presents the result to a consumer through a valid/ready handshake, then re-arms for the next frame.

---
 rtl/nn_argmax_classifier.sv | 134 +++++++++++++
 1 files changed

// File: rtl/nn_argmax_classifier.sv
// Output-layer argmax: captures one frame of activations over per-neuron req/ack,
// scans them one per cycle and presents {class, max} on a valid/ready handshake.
module nn_argmax_classifier #(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned NumOutputs = 10,
    parameter bit          SignedData = 1'b0,
    parameter int unsigned ClassWidth = $clog2(NumOutputs)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [DataWidth*NumOutputs-1:0] actv_i,
    input  logic [NumOutputs-1:0]           req_i,
    output logic [NumOutputs-1:0]           ack_o,
    output logic [ClassWidth-1:0]           class_o,
    output logic [DataWidth-1:0]            max_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            busy_o,
    output logic [15:0]                     frame_cnt_o
);

    typedef enum logic [1:0] {StCollect, StScan, StResult} state_e;

    localparam logic [ClassWidth-1:0] LastIdx = ClassWidth'(NumOutputs - 1);

    state_e                 state_q, state_d;
    logic [NumOutputs-1:0]  captured_q, captured_d;
    logic [NumOutputs-1:0]  ack_q, ack_d;
    logic [NumOutputs-1:0]  grab;
    logic [DataWidth-1:0]   vals_q [NumOutputs];
    logic [ClassWidth-1:0]  idx_q, idx_d;
    logic [ClassWidth-1:0]  best_idx_q, best_idx_d;
    logic [ClassWidth-1:0]  class_q, class_d;
    logic [DataWidth-1:0]   best_q, best_d;
    logic [DataWidth-1:0]   max_q, max_d;
    logic [DataWidth-1:0]   cur;
    logic                   cur_gt;
    logic [15:0]            frame_cnt_q, frame_cnt_d;

    // Only neurons not yet captured this frame are latched and acked.
    assign grab = (state_q == StCollect) ? (req_i & ~captured_q) : '0;
    assign cur  = vals_q[idx_q];

    always_comb begin
        if (SignedData) begin
            cur_gt = $signed(cur) > $signed(best_q);
        end else begin
            cur_gt = cur > best_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        captured_d  = captured_q;
        ack_d       = '0;
        idx_d       = idx_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        class_d     = class_q;
        max_d       = max_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StCollect: begin
                captured_d = captured_q | grab;
                ack_d      = grab;
                idx_d      = '0;
                if (&captured_d) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                idx_d = idx_q + ClassWidth'(1);
                // Strict greater-than keeps the lowest index on ties.
                if (idx_q == '0 || cur_gt) begin
                    best_d     = cur;
                    best_idx_d = idx_q;
                end
                if (idx_q == LastIdx) begin
                    class_d = best_idx_d;
                    max_d   = best_d;
                    state_d = StResult;
                end
            end
            StResult: begin
                if (ready_i) begin
                    state_d     = StCollect;
                    captured_d  = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= StCollect;
            captured_q  <= '0;
            ack_q       <= '0;
            idx_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            class_q     <= '0;
            max_q       <= '0;
            frame_cnt_q <= '0;
            for (int unsigned k = 0; k < NumOutputs; k++) begin
                vals_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            captured_q  <= captured_d;
            ack_q       <= ack_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            class_q     <= class_d;
            max_q       <= max_d;
            frame_cnt_q <= frame_cnt_d;
            for (int unsigned k = 0; k < NumOutputs; k++) begin
                if (grab[k]) begin
                    vals_q[k] <= actv_i[k*DataWidth +: DataWidth];
                end
            end
        end
    end

    assign ack_o       = ack_q;
    assign class_o     = class_q;
    assign max_o       = max_q;
    assign valid_o     = (state_q == StResult);
    assign busy_o      = (state_q != StCollect);
    assign frame_cnt_o = frame_cnt_q;

endmodule
